// File: rtl/regfile_rename_mp_if.sv
// Rename register-file bus: commit, rename, flush and operand-read signals.
// Checkpoint strobes exist only when REGFILE_CKPT_EN is defined.
interface regfile_rename_mp_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned RD_PORTS = 3,
    parameter int unsigned WR_PORTS = 2
);
    logic [WR_PORTS-1:0]        cm_en;
    logic [WR_PORTS*REG_AW-1:0] cm_reg;
    logic [WR_PORTS*DATA_W-1:0] cm_data;
    logic [WR_PORTS*TAG_W-1:0]  cm_tag;
    logic                       rn_en;
    logic [REG_AW-1:0]          rn_reg;
    logic [TAG_W-1:0]           rn_tag;
    logic                       flush;
    logic [RD_PORTS*REG_AW-1:0] rd_name;
    logic [RD_PORTS*DATA_W-1:0] rd_data;
    logic [RD_PORTS*TAG_W-1:0]  rd_tag;
    logic [RD_PORTS-1:0]        rd_busy;
`ifdef REGFILE_CKPT_EN
    logic                       ckpt_save;
    logic                       ckpt_restore;

    modport master (
        output cm_en, cm_reg, cm_data, cm_tag, rn_en, rn_reg, rn_tag, flush, rd_name,
               ckpt_save, ckpt_restore,
        input  rd_data, rd_tag, rd_busy
    );
    modport slave (
        input  cm_en, cm_reg, cm_data, cm_tag, rn_en, rn_reg, rn_tag, flush, rd_name,
               ckpt_save, ckpt_restore,
        output rd_data, rd_tag, rd_busy
    );
`else
    modport master (
        output cm_en, cm_reg, cm_data, cm_tag, rn_en, rn_reg, rn_tag, flush, rd_name,
        input  rd_data, rd_tag, rd_busy
    );
    modport slave (
        input  cm_en, cm_reg, cm_data, cm_tag, rn_en, rn_reg, rn_tag, flush, rd_name,
        output rd_data, rd_tag, rd_busy
    );
`endif
endinterface

// File: rtl/regfile_rename_mp.sv
// Architectural register file with busy/tag rename status, multi-port commit and
// commit-to-read bypass. Define REGFILE_CKPT_EN for a single busy/tag checkpoint.
module regfile_rename_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_N    = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned RD_PORTS = 3,
    parameter int unsigned WR_PORTS = 2
) (
    input logic                clk,
    input logic                rst,
    regfile_rename_mp_if.slave bus
);
    logic [DATA_W-1:0] data_q [REG_N];
    logic [DATA_W-1:0] data_n [REG_N];
    logic              busy_q [REG_N];
    logic              busy_n [REG_N];
    logic [TAG_W-1:0]  tag_q  [REG_N];
    logic [TAG_W-1:0]  tag_n  [REG_N];

    logic [REG_AW-1:0] cm_reg_a  [WR_PORTS];
    logic [DATA_W-1:0] cm_data_a [WR_PORTS];
    logic [TAG_W-1:0]  cm_tag_a  [WR_PORTS];

    // Unflatten commit buses
    always_comb begin
        for (int unsigned k = 0; k < WR_PORTS; k++) begin
            cm_reg_a[k]  = bus.cm_reg[k*REG_AW +: REG_AW];
            cm_data_a[k] = bus.cm_data[k*DATA_W +: DATA_W];
            cm_tag_a[k]  = bus.cm_tag[k*TAG_W +: TAG_W];
        end
    end

`ifdef REGFILE_CKPT_EN
    logic              sh_busy_q [REG_N];
    logic              sh_busy_n [REG_N];
    logic [TAG_W-1:0]  sh_tag_q  [REG_N];
    logic [TAG_W-1:0]  sh_tag_n  [REG_N];
`endif

    // Next state: commits, then rename, then flush/checkpoint overrides
    always_comb begin
        logic live_clr;
        logic sh_clr;
        data_n   = data_q;
        busy_n   = busy_q;
        tag_n    = tag_q;
        live_clr = 1'b0;
        sh_clr   = 1'b0;
`ifdef REGFILE_CKPT_EN
        sh_busy_n = sh_busy_q;
        sh_tag_n  = sh_tag_q;
`endif
        for (int unsigned r = 1; r < REG_N; r++) begin
            live_clr = 1'b0;
            sh_clr   = 1'b0;
            for (int unsigned k = 0; k < WR_PORTS; k++) begin
                if (bus.cm_en[k] && cm_reg_a[k] == REG_AW'(r)) begin
                    data_n[r] = cm_data_a[k];
                    if (cm_tag_a[k] == tag_q[r]) live_clr = 1'b1;
`ifdef REGFILE_CKPT_EN
                    if (cm_tag_a[k] == sh_tag_q[r]) sh_clr = 1'b1;
`endif
                end
            end
            if (live_clr) busy_n[r] = 1'b0;
            if (bus.rn_en && bus.rn_reg == REG_AW'(r)) begin
                busy_n[r] = 1'b1;
                tag_n[r]  = bus.rn_tag;
            end
`ifdef REGFILE_CKPT_EN
            if (sh_clr) sh_busy_n[r] = 1'b0;
            if (bus.ckpt_restore) begin
                busy_n[r] = sh_busy_q[r] & ~sh_clr;
                tag_n[r]  = sh_tag_q[r];
            end else if (bus.flush) begin
                busy_n[r] = 1'b0;
                tag_n[r]  = tag_q[r];
            end else if (bus.ckpt_save) begin
                sh_busy_n[r] = busy_n[r];
                sh_tag_n[r]  = tag_n[r];
            end
`else
            if (bus.flush) begin
                busy_n[r] = 1'b0;
                tag_n[r]  = tag_q[r];
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < REG_N; r++) begin
                data_q[r] <= '0;
                busy_q[r] <= 1'b0;
                tag_q[r]  <= '0;
            end
        end else begin
            data_q <= data_n;
            busy_q <= busy_n;
            tag_q  <= tag_n;
        end
    end

`ifdef REGFILE_CKPT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < REG_N; r++) begin
                sh_busy_q[r] <= 1'b0;
                sh_tag_q[r]  <= '0;
            end
        end else begin
            sh_busy_q <= sh_busy_n;
            sh_tag_q  <= sh_tag_n;
        end
    end
`endif

    logic [RD_PORTS*DATA_W-1:0] rd_data_v;
    logic [RD_PORTS*TAG_W-1:0]  rd_tag_v;
    logic [RD_PORTS-1:0]        rd_busy_v;

    // Operand read with same-cycle commit bypass; renames and flush are not forwarded
    always_comb begin
        logic [REG_AW-1:0] idx;
        logic [DATA_W-1:0] d;
        logic              b;
        rd_data_v = '0;
        rd_tag_v  = '0;
        rd_busy_v = '0;
        idx       = '0;
        d         = '0;
        b         = 1'b0;
        for (int unsigned p = 0; p < RD_PORTS; p++) begin
            idx = bus.rd_name[p*REG_AW +: REG_AW];
            d   = data_q[idx];
            b   = busy_q[idx];
            for (int unsigned k = 0; k < WR_PORTS; k++) begin
                if (bus.cm_en[k] && cm_reg_a[k] == idx) begin
                    d = cm_data_a[k];
                    if (cm_tag_a[k] == tag_q[idx]) b = 1'b0;
                end
            end
            if (!rst && idx != '0) begin
                rd_data_v[p*DATA_W +: DATA_W] = d;
                rd_tag_v[p*TAG_W +: TAG_W]    = tag_q[idx];
                rd_busy_v[p]                  = b;
            end
        end
    end

    assign bus.rd_data = rd_data_v;
    assign bus.rd_tag  = rd_tag_v;
    assign bus.rd_busy = rd_busy_v;

endmodule

// File: tb/tb_regfile_rename_mp.sv
// Self-checking bench for regfile_rename_mp: directed scenarios plus a randomized
// run against a register-level reference model.
module tb_regfile_rename_mp;
    localparam int unsigned DW = 32;
    localparam int unsigned RN = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned TW = 4;
    localparam int unsigned RP = 3;
    localparam int unsigned WP = 2;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    regfile_rename_mp_if #(.DATA_W(DW), .REG_AW(AW), .TAG_W(TW), .RD_PORTS(RP), .WR_PORTS(WP)) bus ();

    regfile_rename_mp #(.DATA_W(DW), .REG_N(RN), .REG_AW(AW), .TAG_W(TW),
                        .RD_PORTS(RP), .WR_PORTS(WP)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [DW-1:0] m_data [RN];
    logic          m_busy [RN];
    logic [TW-1:0] m_tag  [RN];
`ifdef REGFILE_CKPT_EN
    logic          m_sbusy [RN];
    logic [TW-1:0] m_stag  [RN];
`endif

    function automatic logic [DW-1:0] rdd(int p); return bus.rd_data[p*DW +: DW]; endfunction
    function automatic logic [TW-1:0] rdt(int p); return bus.rd_tag[p*TW +: TW]; endfunction
    function automatic logic          rdb(int p); return bus.rd_busy[p]; endfunction

    task automatic idle();
        bus.cm_en = '0; bus.cm_reg = '0; bus.cm_data = '0; bus.cm_tag = '0;
        bus.rn_en = 1'b0; bus.rn_reg = '0; bus.rn_tag = '0; bus.flush = 1'b0;
        bus.rd_name = '0;
`ifdef REGFILE_CKPT_EN
        bus.ckpt_save = 1'b0; bus.ckpt_restore = 1'b0;
`endif
    endtask

    task automatic commit(int k, logic [AW-1:0] r, logic [DW-1:0] d, logic [TW-1:0] t);
        bus.cm_en[k] = 1'b1;
        bus.cm_reg[k*AW +: AW]  = r;
        bus.cm_data[k*DW +: DW] = d;
        bus.cm_tag[k*TW +: TW]  = t;
    endtask

    task automatic rename(logic [AW-1:0] r, logic [TW-1:0] t);
        bus.rn_en = 1'b1; bus.rn_reg = r; bus.rn_tag = t;
    endtask

    task automatic read_all(logic [AW-1:0] r);
        for (int p = 0; p < RP; p++) bus.rd_name[p*AW +: AW] = r;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; idle(); tick(); tick(); rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        read_all(5'd5); commit(0, 5'd5, 32'hCAFE_F00D, 4'd0);
        #1;
        for (int p = 0; p < RP; p++) begin
            n_cmp++;
            if (rdd(p) !== '0 || rdb(p) !== 1'b0 || rdt(p) !== '0) begin
                n_bad++; $display("FAIL reset_outputs p%0d got d=%h b=%b t=%h want 0", p, rdd(p), rdb(p), rdt(p));
            end
        end
        tick(); tick(); rst = 1'b0; idle(); read_all(5'd5); #1;
        for (int p = 0; p < RP; p++) begin
            n_cmp++;
            if (rdd(p) !== '0 || rdb(p) !== 1'b0) begin
                n_bad++; $display("FAIL reset_r5 p%0d got d=%h b=%b want d=0 b=0", p, rdd(p), rdb(p));
            end
        end
    endtask

    task automatic test_commit_clear();
        idle(); rename(5'd5, 4'd3); tick();
        idle(); read_all(5'd5); #1;
        n_cmp++;
        if (rdb(0) !== 1'b1 || rdt(0) !== 4'd3) begin
            n_bad++; $display("FAIL rename_r5 got b=%b t=%h want b=1 t=3", rdb(0), rdt(0));
        end
        commit(1, 5'd5, 32'hDEAD_BEEF, 4'd3); #1;
        n_cmp++;
        if (rdd(2) !== 32'hDEAD_BEEF || rdb(2) !== 1'b0) begin
            n_bad++; $display("FAIL bypass_r5 got d=%h b=%b want d=deadbeef b=0", rdd(2), rdb(2));
        end
        tick(); idle(); read_all(5'd5); #1;
        n_cmp++;
        if (rdd(1) !== 32'hDEAD_BEEF || rdb(1) !== 1'b0) begin
            n_bad++; $display("FAIL stored_r5 got d=%h b=%b want d=deadbeef b=0", rdd(1), rdb(1));
        end
    endtask

    task automatic test_stale_commit();
        idle(); rename(5'd7, 4'd2); tick();
        idle(); rename(5'd7, 4'd6); tick();
        idle(); commit(0, 5'd7, 32'h11, 4'd2); tick();
        idle(); read_all(5'd7); #1;
        n_cmp++;
        if (rdd(0) !== 32'h11 || rdb(0) !== 1'b1 || rdt(0) !== 4'd6) begin
            n_bad++; $display("FAIL stale_commit_r7 got d=%h b=%b t=%h want d=11 b=1 t=6", rdd(0), rdb(0), rdt(0));
        end
    endtask

    task automatic test_bypass_rename();
        idle(); rename(5'd4, 4'd1); tick();
        idle(); commit(0, 5'd4, 32'h55, 4'd1); rename(5'd4, 4'd9); read_all(5'd4); #1;
        n_cmp++;
        if (rdd(1) !== 32'h55 || rdb(1) !== 1'b0) begin
            n_bad++; $display("FAIL bypass_r4 got d=%h b=%b want d=55 b=0", rdd(1), rdb(1));
        end
        tick(); idle(); read_all(5'd4); #1;
        n_cmp++;
        if (rdd(0) !== 32'h55 || rdb(0) !== 1'b1 || rdt(0) !== 4'd9) begin
            n_bad++; $display("FAIL rename_wins_r4 got d=%h b=%b t=%h want d=55 b=1 t=9", rdd(0), rdb(0), rdt(0));
        end
    endtask

    task automatic test_multi_commit();
        idle(); rename(5'd8, 4'd5); tick();
        idle(); commit(0, 5'd8, 32'hA, 4'd5); commit(1, 5'd8, 32'hB, 4'd2); read_all(5'd8); #1;
        for (int p = 0; p < RP; p++) begin
            n_cmp++;
            if (rdd(p) !== 32'hB || rdb(p) !== 1'b0) begin
                n_bad++; $display("FAIL multi_bypass_r8 p%0d got d=%h b=%b want d=b b=0", p, rdd(p), rdb(p));
            end
        end
        tick(); idle(); read_all(5'd8); #1;
        n_cmp++;
        if (rdd(2) !== 32'hB || rdb(2) !== 1'b0) begin
            n_bad++; $display("FAIL multi_stored_r8 got d=%h b=%b want d=b b=0", rdd(2), rdb(2));
        end
    endtask

    task automatic test_flush_r0();
        for (int i = 1; i < RN; i++) begin
            idle(); rename(AW'(i), TW'(i)); tick();
        end
        idle();
        bus.flush = 1'b1; rename(5'd2, 4'hA);
        commit(0, 5'd9, 32'h99, 4'd0); commit(1, 5'd0, 32'hFFFF, 4'd0);
        bus.rd_name = {5'd0, 5'd9, 5'd3}; #1;
        n_cmp++;
        if (rdb(0) !== 1'b1 || rdt(0) !== 4'd3) begin
            n_bad++; $display("FAIL flush_not_bypassed got b=%b t=%h want b=1 t=3", rdb(0), rdt(0));
        end
        n_cmp++;
        if (rdd(1) !== 32'h99 || rdb(1) !== 1'b1) begin
            n_bad++; $display("FAIL flush_cycle_r9 got d=%h b=%b want d=99 b=1", rdd(1), rdb(1));
        end
        n_cmp++;
        if (rdd(2) !== '0 || rdb(2) !== 1'b0 || rdt(2) !== '0) begin
            n_bad++; $display("FAIL r0_bypass got d=%h b=%b t=%h want 0", rdd(2), rdb(2), rdt(2));
        end
        tick(); idle();
        for (int r = 0; r < RN; r++) begin
            read_all(AW'(r)); #1;
            n_cmp++;
            if (rdb(r % RP) !== 1'b0) begin
                n_bad++; $display("FAIL flush_busy r%0d got %b want 0", r, rdb(r % RP));
            end
        end
        read_all(5'd9); #1;
        n_cmp++;
        if (rdd(0) !== 32'h99) begin
            n_bad++; $display("FAIL flush_commit_data r9 got %h want 99", rdd(0));
        end
        idle(); rename(5'd0, 4'd5); commit(0, 5'd0, 32'h1234, 4'd5); tick();
        idle(); read_all(5'd0); #1;
        n_cmp++;
        if (rdd(1) !== '0 || rdb(1) !== 1'b0 || rdt(1) !== '0) begin
            n_bad++; $display("FAIL r0_stored got d=%h b=%b t=%h want 0", rdd(1), rdb(1), rdt(1));
        end
    endtask

`ifdef REGFILE_CKPT_EN
    task automatic test_ckpt();
        idle(); rename(5'd3, 4'd4); tick();
        idle(); bus.ckpt_save = 1'b1; tick();
        idle(); rename(5'd3, 4'd7); tick();
        idle(); commit(0, 5'd3, 32'h3, 4'd4); tick();
        idle(); read_all(5'd3); #1;
        n_cmp++;
        if (rdb(0) !== 1'b1 || rdt(0) !== 4'd7) begin
            n_bad++; $display("FAIL ckpt_live_r3 got b=%b t=%h want b=1 t=7", rdb(0), rdt(0));
        end
        bus.ckpt_restore = 1'b1; tick();
        idle(); read_all(5'd3); #1;
        n_cmp++;
        if (rdb(0) !== 1'b0) begin
            n_bad++; $display("FAIL ckpt_restore_cleared r3 got b=%b want 0", rdb(0));
        end
        idle(); rename(5'd3, 4'd4); tick();
        idle(); bus.ckpt_save = 1'b1; tick();
        idle(); rename(5'd3, 4'd7); tick();
        idle(); bus.ckpt_restore = 1'b1; tick();
        idle(); read_all(5'd3); #1;
        n_cmp++;
        if (rdb(1) !== 1'b1 || rdt(1) !== 4'd4) begin
            n_bad++; $display("FAIL ckpt_restore_r3 got b=%b t=%h want b=1 t=4", rdb(1), rdt(1));
        end
    endtask
`endif

    // Reference model: apply one clock edge of architectural update from held inputs
    task automatic model_edge();
        logic [DW-1:0] nd [RN];
        logic          nb [RN];
        logic [TW-1:0] nt [RN];
        logic          live_hit [RN];
        logic          sh_hit [RN];
        logic [AW-1:0] r;
        nd = m_data; nb = m_busy; nt = m_tag;
        for (int i = 0; i < RN; i++) begin live_hit[i] = 1'b0; sh_hit[i] = 1'b0; end
        for (int k = 0; k < WP; k++) begin
            r = bus.cm_reg[k*AW +: AW];
            if (bus.cm_en[k] && r != 0) begin
                nd[r] = bus.cm_data[k*DW +: DW];
                if (bus.cm_tag[k*TW +: TW] == m_tag[r]) live_hit[r] = 1'b1;
`ifdef REGFILE_CKPT_EN
                if (bus.cm_tag[k*TW +: TW] == m_stag[r]) sh_hit[r] = 1'b1;
`endif
            end
        end
        for (int i = 0; i < RN; i++) if (live_hit[i]) nb[i] = 1'b0;
`ifdef REGFILE_CKPT_EN
        for (int i = 0; i < RN; i++) if (sh_hit[i]) m_sbusy[i] = 1'b0;
        if (bus.ckpt_restore) begin
            for (int i = 0; i < RN; i++) begin nb[i] = m_sbusy[i]; nt[i] = m_stag[i]; end
        end else if (bus.flush) begin
            for (int i = 0; i < RN; i++) nb[i] = 1'b0;
        end else begin
            if (bus.rn_en && bus.rn_reg != 0) begin nb[bus.rn_reg] = 1'b1; nt[bus.rn_reg] = bus.rn_tag; end
            if (bus.ckpt_save) begin m_sbusy = nb; m_stag = nt; end
        end
`else
        if (bus.flush) begin
            for (int i = 0; i < RN; i++) nb[i] = 1'b0;
        end else if (bus.rn_en && bus.rn_reg != 0) begin
            nb[bus.rn_reg] = 1'b1; nt[bus.rn_reg] = bus.rn_tag;
        end
`endif
        m_data = nd; m_busy = nb; m_tag = nt;
    endtask

    task automatic test_random();
        logic [AW-1:0] r;
        logic [TW-1:0] t;
        logic [DW-1:0] ed;
        logic          eb;
        logic [AW-1:0] n;
        do_reset();
        for (int i = 0; i < RN; i++) begin
            m_data[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
`ifdef REGFILE_CKPT_EN
            m_sbusy[i] = 1'b0; m_stag[i] = '0;
`endif
        end
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int k = 0; k < WP; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    r = AW'($urandom_range(0, 7));
                    t = ($urandom_range(0, 1) == 1) ? m_tag[r] : TW'($urandom);
                    commit(k, r, $urandom, t);
                end
            end
            if ($urandom_range(0, 1) == 1) rename(AW'($urandom_range(0, 7)), TW'($urandom));
            bus.flush = ($urandom_range(0, 15) == 0);
`ifdef REGFILE_CKPT_EN
            bus.ckpt_save    = ($urandom_range(0, 9) == 0);
            bus.ckpt_restore = ($urandom_range(0, 11) == 0);
`endif
            for (int p = 0; p < RP; p++) bus.rd_name[p*AW +: AW] = AW'($urandom_range(0, 7));
            #1;
            for (int p = 0; p < RP; p++) begin
                n  = bus.rd_name[p*AW +: AW];
                ed = m_data[n];
                eb = m_busy[n];
                for (int k = 0; k < WP; k++) begin
                    if (bus.cm_en[k] && bus.cm_reg[k*AW +: AW] == n) begin
                        ed = bus.cm_data[k*DW +: DW];
                        if (bus.cm_tag[k*TW +: TW] == m_tag[n]) eb = 1'b0;
                    end
                end
                if (n == 0) begin ed = '0; eb = 1'b0; end
                n_cmp++;
                if (rdd(p) !== ed || rdb(p) !== eb || (eb && rdt(p) !== m_tag[n])) begin
                    n_bad++;
                    $display("FAIL random c%0d p%0d r%0d got d=%h b=%b t=%h want d=%h b=%b t=%h",
                             c, p, n, rdd(p), rdb(p), rdt(p), ed, eb, m_tag[n]);
                end
            end
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        idle();
        test_reset();
        test_commit_clear();
        test_stale_commit();
        test_bypass_rename();
        test_multi_commit();
        test_flush_r0();
`ifdef REGFILE_CKPT_EN
        test_ckpt();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
